perip_lsu: RTL and testbench
============================

PERIP_LSU -- requirements
Module: perip_lsu

Interface
REQ-001 Parameter: READ_LATENCY, 1, cycles from perip_addr valid to perip_rdata valid (1..3).
REQ-002 Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU memory request present.
- req_ready  out  1  request accepted this cycle when req_valid & req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 reserved.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, low-aligned.
- resp_valid  out  1  one-cycle pulse completing the accepted request.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned address or reserved size.
- perip_addr  out  32  bus byte address.
- perip_wdata  out  32  bus store data, low-aligned.
- perip_wen  out  1  bus write strobe.
- perip_mask  out  2  bus access size, same encoding as req_size.
- perip_rdata  in  32  word read from the word-aligned perip_addr.

Function
REQ-003 The block SHALL implement states IDLE, WRITE, READ_WAIT, RESP.
REQ-004 The block SHALL drive req_ready=1 only in IDLE; a request SHALL be accepted only when req_valid=1 and the state is IDLE.
REQ-005 On acceptance the block SHALL register addr, size, unsigned flag and wdata; later req_* changes SHALL NOT affect the transaction.
REQ-006 The block SHALL flag misalignment when: half with addr[0]=1; word with addr[1:0]!=0; or size=11.
REQ-007 A misaligned accept SHALL go IDLE->RESP, issue no bus access, and pulse resp_valid=1 with resp_err=1 and resp_rdata=0 the next cycle.
REQ-008 An aligned store SHALL go IDLE->WRITE and drive perip_wen=1 for exactly one cycle, with registered perip_addr, perip_wdata and perip_mask.
REQ-009 After the WRITE cycle the block SHALL go to RESP and pulse resp_valid=1, resp_err=0, resp_rdata=0.
REQ-010 An aligned load SHALL go IDLE->READ_WAIT with perip_wen=0 and hold perip_addr/perip_mask constant for READ_LATENCY cycles.
REQ-011 After READ_LATENCY cycles the block SHALL sample perip_rdata and go to RESP.
REQ-012 Load extraction SHALL use addr[1:0]:
- byte: lane addr[1:0]*8.
- half: lane addr[1]*16.
- Sign-extend from bit 7 or bit 15 unless unsigned; word loads pass through unchanged.
REQ-013 RESP SHALL last one cycle, return to IDLE, and raise req_ready in the following cycle.
- Store latency: accept to resp_valid = 2 cycles.
- Load latency: accept to resp_valid = READ_LATENCY+1 cycles.
REQ-014 Outside WRITE, perip_wen SHALL be 0; perip_addr/wdata/mask SHALL hold their last values.
REQ-015 resp_rdata and resp_err SHALL be 0 whenever resp_valid=0.
REQ-016 Back-to-back requests SHALL be serviced in order with no bus overlap; maximum throughput is one request per latency+1 cycles.

Reset
REQ-017 While rst=1 at a clock edge the block SHALL enter IDLE and reset all outputs:
- 0: perip_addr, perip_wdata, perip_wen, perip_mask, resp_valid, resp_rdata, resp_err.
- 1: req_ready.
REQ-018 Reset asserted mid-transaction SHALL abort it with no resp_valid pulse. If rst rises in the WRITE cycle, perip_wen SHALL be 0 from the next edge onward.
REQ-019 req_valid during rst=1 SHALL be ignored.

Verification
REQ-020 Word store 0xDEADBEEF to 0x80000010 -> exactly one perip_wen cycle with perip_addr=0x80000010, perip_mask=10; resp_valid 2 cycles after accept, resp_err=0.
REQ-021 Signed byte load at 0x80000003, perip_rdata=0x80FF7F01 -> resp_rdata=0xFFFFFF80. The same load unsigned -> 0x00000080.
REQ-022 Half load at 0x80000002 (signed), perip_rdata=0x7FFF1234 -> resp_rdata=0x00007FFF.
REQ-023 Word load at 0x80000006 -> no perip_wen, resp_err=1, resp_rdata=0, resp_valid 1 cycle after accept.
REQ-024 rst pulsed in READ_WAIT -> no resp_valid, req_ready=1 after reset. A subsequent store then completes normally.
REQ-025 READ_LATENCY=3, req_valid held high for 3 requests -> accepts spaced exactly 5 cycles apart for loads and 3 for stores, in request order.

Source files
------------

// File: rtl/perip_lsu.sv
// Load/store unit that bridges single CPU requests onto a simple peripheral bus.
// It handles one request at a time, checks alignment, and sign/zero-extends load data.
module perip_lsu #(
  parameter int READ_LATENCY = 1  // 1..3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] perip_addr,
  output logic [31:0] perip_wdata,
  output logic        perip_wen,
  output logic [1:0]  perip_mask,
  input  logic [31:0] perip_rdata
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    READ_WAIT = 2'd2,
    RESP      = 2'd3
  } state_e;

  localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY - 1);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  mask_q, mask_d;
  logic        uns_q, uns_d;
  logic        wen_q, wen_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic        accept;
  logic        misaligned;
  logic [7:0]  byte_lane [4];
  logic [15:0] half_lane [2];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  // Split the returned word into lanes so extraction is a plain index by address.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
      assign byte_lane[gi] = perip_rdata[gi*8 +: 8];
    end
    for (genvar gi = 0; gi < 2; gi++) begin : g_half_lane
      assign half_lane[gi] = perip_rdata[gi*16 +: 16];
    end
  endgenerate

  assign byte_sel = byte_lane[addr_q[1:0]];
  assign half_sel = half_lane[addr_q[1]];

  always_comb begin
    load_ext = perip_rdata;
    case (mask_q)
      2'b00:   load_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
      default: load_ext = perip_rdata;
    endcase
  end

  assign accept     = req_valid && (state_q == IDLE);
  assign misaligned = (req_size == 2'b11) ||
                      ((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    uns_d        = uns_q;
    wen_d        = 1'b0;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'd0;
    resp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (misaligned) begin
            // Rejected without touching the bus; bus outputs keep their last values.
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            addr_d = req_addr;
            mask_d = req_size;
            uns_d  = req_unsigned;
            if (req_we) begin
              wdata_d = req_wdata;
              wen_d   = 1'b1;
              state_d = WRITE;
            end else begin
              cnt_d   = LAT_INIT;
              state_d = READ_WAIT;
            end
          end
        end
      end
      WRITE: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      READ_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_ext;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      mask_q       <= 2'd0;
      uns_q        <= 1'b0;
      wen_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mask_q       <= mask_d;
      uns_q        <= uns_d;
      wen_q        <= wen_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;
  assign perip_addr  = addr_q;
  assign perip_wdata = wdata_q;
  assign perip_wen   = wen_q;
  assign perip_mask  = mask_q;

endmodule

// File: tb/tb_perip_lsu.sv
// Randomised and directed bench for perip_lsu against a behavioural load/store model.
// The bench plays the peripheral: read data is only valid in the cycle the LSU should sample it.
module tb_perip_lsu;

  localparam int LAT = 3;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] perip_addr;
  logic [31:0] perip_wdata;
  logic        perip_wen;
  logic [1:0]  perip_mask;
  logic [31:0] perip_rdata;

  int          n_checks;
  int          n_errors;
  logic [31:0] last_addr;

  perip_lsu #(.READ_LATENCY(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .perip_addr   (perip_addr),
    .perip_wdata  (perip_wdata),
    .perip_wen    (perip_wen),
    .perip_mask   (perip_mask),
    .perip_rdata  (perip_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic is_mis(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns,
                                           input logic [31:0] addr, input logic [31:0] word);
    int unsigned v;
    case (size)
      2'd0: begin
        v = (word >> (8 * (addr % 4))) % 256;
        if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
      end
      2'd1: begin
        v = (word >> (16 * ((addr % 4) / 2))) % 65536;
        if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_req(input string tag, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] word);
    logic        err;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          n;
    int          k;
    int          wen_cnt;
    bit          got;
    err     = is_mis(size, addr);
    exp_rd  = (err || we) ? 32'd0 : ref_load(size, uns, addr, word);
    exp_lat = err ? 1 : (we ? 2 : LAT + 1);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    chk({tag, "/accept_timeout"}, 32'(n >= 50), 32'd0);
    step();
    // Scramble the request after acceptance; the transaction must use its captured copy.
    req_valid = 1'b0;
    req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    k = 1; wen_cnt = 0; got = 0;
    while (!got && k <= LAT + 4) begin
      perip_rdata = (k == LAT) ? word : $urandom;
      if (perip_wen) begin
        wen_cnt++;
        chk({tag, "/waddr"}, perip_addr, addr);
        chk({tag, "/wmask"}, 32'(perip_mask), 32'(size));
        chk({tag, "/wdata"}, perip_wdata, wdata);
      end
      if (!err && !we && k <= LAT) begin
        chk({tag, "/raddr"}, perip_addr, addr);
        chk({tag, "/rmask"}, 32'(perip_mask), 32'(size));
      end
      if (err) chk({tag, "/mis_hold"}, perip_addr, last_addr);
      if (resp_valid) begin
        got = 1;
        chk({tag, "/latency"}, 32'(k), 32'(exp_lat));
        chk({tag, "/err"}, 32'(resp_err), 32'(err));
        chk({tag, "/rdata"}, resp_rdata, exp_rd);
      end else begin
        chk({tag, "/quiet_rdata"}, resp_rdata, 32'd0);
        chk({tag, "/quiet_err"}, 32'(resp_err), 32'd0);
        chk({tag, "/busy"}, 32'(req_ready), 32'd0);
      end
      if (!got) begin
        step();
        k++;
      end
    end
    chk({tag, "/resp_timeout"}, 32'(got), 32'd1);
    chk({tag, "/wen_cycles"}, 32'(wen_cnt), 32'((!err && we) ? 1 : 0));
    $display("txn %-12s we=%0d size=%0d uns=%0d addr=%08h -> rdata=%08h err=%0d lat=%0d",
             tag, we, size, uns, addr, resp_rdata, resp_err, k);
    step();
    chk({tag, "/resp_pulse"}, 32'(resp_valid), 32'd0);
    chk({tag, "/ready_after"}, 32'(req_ready), 32'd1);
    if (!err) last_addr = addr;
  endtask

  // Three requests with req_valid held high; checks spacing, order and bus activity.
  task automatic batch(input logic we);
    logic [31:0] a  [3];
    logic [31:0] wd [3];
    logic [1:0]  s  [3];
    int          acc [3];
    int          idx;
    int          ridx;
    int          widx;
    int          cyc;
    int          gap;
    bit          adv;
    logic [31:0] w;
    w  = $urandom;
    perip_rdata = w;
    a  = '{32'h8000_0021, 32'h8000_0026, 32'h8000_0028};
    s  = '{2'd0, 2'd1, 2'd2};
    wd = '{$urandom, $urandom, $urandom};
    acc = '{0, 0, 0};
    gap = we ? 3 : LAT + 2;
    idx = 0; ridx = 0; widx = 0; cyc = 0;
    req_we = we; req_size = s[0]; req_unsigned = 1'b0; req_addr = a[0]; req_wdata = wd[0];
    req_valid = 1'b1;
    while (ridx < 3 && cyc < 80) begin
      adv = 0;
      if (resp_valid) begin
        chk("b2b/rdata", resp_rdata, we ? 32'd0 : ref_load(s[ridx], 1'b0, a[ridx], w));
        chk("b2b/err", 32'(resp_err), 32'd0);
        ridx++;
      end
      if (perip_wen && widx < 3) begin
        chk("b2b/waddr", perip_addr, a[widx]);
        chk("b2b/wdata", perip_wdata, wd[widx]);
        widx++;
      end
      if (req_valid && req_ready && idx < 3) begin
        acc[idx] = cyc;
        idx++;
        adv = 1;
      end
      step();
      cyc++;
      if (adv) begin
        if (idx < 3) begin
          req_size = s[idx]; req_addr = a[idx]; req_wdata = wd[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    chk("b2b/responses", 32'(ridx), 32'd3);
    chk("b2b/accepts", 32'(idx), 32'd3);
    chk("b2b/writes", 32'(widx), we ? 32'd3 : 32'd0);
    chk("b2b/gap01", 32'(acc[1] - acc[0]), 32'(gap));
    chk("b2b/gap12", 32'(acc[2] - acc[1]), 32'(gap));
    $display("txn b2b we=%0d accepts at cycles %0d %0d %0d", we, acc[0], acc[1], acc[2]);
    last_addr = a[2];
    step();
  endtask

  initial begin
    n_checks = 0; n_errors = 0; last_addr = 32'd0;
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h8000_0000; req_wdata = 32'h1234_5678; perip_rdata = 32'd0;
    // Requests presented during reset must be ignored.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst/ready", 32'(req_ready), 32'd1);
      chk("rst/resp_valid", 32'(resp_valid), 32'd0);
      chk("rst/wen", 32'(perip_wen), 32'd0);
    end
    rst = 1'b0; req_valid = 1'b0;
    chk("rst/addr", perip_addr, 32'd0);
    chk("rst/wdata", perip_wdata, 32'd0);
    chk("rst/mask", 32'(perip_mask), 32'd0);
    chk("rst/rdata", resp_rdata, 32'd0);
    chk("rst/err", 32'(resp_err), 32'd0);
    step();
    chk("rst/no_resp", 32'(resp_valid), 32'd0);

    run_req("st_word", 1'b1, 2'd2, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 32'd0);
    run_req("ld_sb", 1'b0, 2'd0, 1'b0, 32'h8000_0003, 32'd0, 32'h80FF_7F01);
    run_req("ld_ub", 1'b0, 2'd0, 1'b1, 32'h8000_0003, 32'd0, 32'h80FF_7F01);
    run_req("ld_sh", 1'b0, 2'd1, 1'b0, 32'h8000_0002, 32'd0, 32'h7FFF_1234);
    run_req("ld_mis_w", 1'b0, 2'd2, 1'b0, 32'h8000_0006, 32'd0, 32'hFFFF_FFFF);
    run_req("ld_rsvd", 1'b0, 2'd3, 1'b0, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF);
    run_req("st_mis_h", 1'b1, 2'd1, 1'b0, 32'h8000_0001, 32'hAAAA_5555, 32'd0);

    // Reset during READ_WAIT aborts the load silently.
    req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h8000_0040;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    chk("abort_rd/busy", 32'(req_ready), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_rd/ready", 32'(req_ready), 32'd1);
    chk("abort_rd/addr", perip_addr, 32'd0);
    last_addr = 32'd0;
    for (int i = 0; i < 6; i++) begin
      perip_rdata = $urandom;
      chk("abort_rd/no_resp", 32'(resp_valid), 32'd0);
      step();
    end
    run_req("st_after_rst", 1'b1, 2'd0, 1'b0, 32'h8000_0045, 32'h0000_00A5, 32'd0);

    // Reset during the WRITE cycle must drop the strobe at the next edge.
    req_we = 1'b1; req_size = 2'd2; req_addr = 32'h8000_0050; req_wdata = 32'hCAFE_F00D;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("abort_wr/wen", 32'(perip_wen), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_wr/wen_drop", 32'(perip_wen), 32'd0);
    last_addr = 32'd0;
    for (int i = 0; i < 4; i++) begin
      chk("abort_wr/no_resp", 32'(resp_valid), 32'd0);
      chk("abort_wr/no_wen", 32'(perip_wen), 32'd0);
      step();
    end

    for (int i = 0; i < 40; i++) begin
      run_req("rand", 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
              32'h8000_0000 + 32'($urandom_range(0, 15)), $urandom, $urandom);
    end

    batch(1'b0);
    batch(1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
